alu_sequencer: RTL

//  Command-side front end for the combinational N-bit ALU (add/sub/mul/div/rem/logic/shift).
//  - Accepts operation requests over a valid/ready handshake.
//  - Registers the operands and drives them to the ALU.
//  - Samples the ALU result and N/Z/C/V flags, then returns them over a valid/ready response channel.
//  - Screens out illegal opcodes and divide-by-zero before a result is released.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_sequencer.sv | 103 ++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Opcode and sequencer-state types shared by alu_sequencer
//                and its clients, plus the illegal-op / divide-by-zero screen.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        MUL = 4'd2,
        DIV = 4'd3,
        REM = 4'd4,
        AND = 4'd5,
        OR  = 4'd6,
        XOR = 4'd7,
        SHL = 4'd8,
        SHR = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } seq_state_e;

    // Highest opcode the ALU implements; anything above is rejected.
    localparam logic [3:0] OP_LAST = 4'h9;

    // True when the ALU result must not be released: unknown opcode, or a
    // division/remainder whose divisor is zero.
    function automatic logic op_faults(input logic [3:0] op, input logic b_is_zero);
        logic w_div_like;
        w_div_like = (op == DIV) || (op == REM);
        return (op > OP_LAST) || (w_div_like && b_is_zero);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Command/response front end for a combinational ALU. Latches
//                one request, lets the ALU settle for a cycle, captures the
//                result and flags (or an error response) and holds them until
//                the consumer takes them. One operation in flight at a time.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [W-1:0]     cmd_a,
    input  logic [W-1:0]     cmd_b,
    input  logic [3:0]       cmd_op,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [9:0]       alu_op,
    input  logic [W-1:0]     alu_result,
    input  logic [3:0]       alu_nzcv,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_result,
    output logic [3:0]       rsp_nzcv,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);

    // Flags reported with an error response: result forced to zero, so Z=1.
    localparam logic [3:0] c_ERR_NZCV = 4'b0100;

    seq_state_e  r_state;
    logic [3:0]  r_op;
    logic        w_err;

    // Handshake strobes follow the state directly, so an asynchronous reset
    // drops rsp_valid in the same instant the state clears.
    always_comb begin
        cmd_ready = (r_state == IDLE);
        rsp_valid = (r_state == HOLD);
        w_err     = op_faults(r_op, (alu_b == '0));
    end

    assign alu_op = {6'b0, r_op};

    // Sequencer FSM together with the operand, response and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op       <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_result <= '0;
            rsp_nzcv   <= '0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a   <= cmd_a;
                        alu_b   <= cmd_b;
                        r_op    <= cmd_op;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands have been stable for a full cycle; sample now.
                    if (w_err) begin
                        rsp_err    <= 1'b1;
                        rsp_result <= '0;
                        rsp_nzcv   <= c_ERR_NZCV;
                    end else begin
                        rsp_err    <= 1'b0;
                        rsp_result <= alu_result;
                        rsp_nzcv   <= alu_nzcv;
                    end
                    r_state <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                        if (op_count != '1) begin
                            op_count <= op_count + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
